// File: rtl/sdram_pkg.sv
// sdram_pkg: shared SDRAM command encodings, arbiter states and default widths
package sdram_pkg;

    localparam int DEF_ADDR_W = 13;
    localparam int DEF_BANK_W = 2;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MRS  = 4'b0000;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARBIT = 3'd1,
        S_AREF  = 3'd2,
        S_WRITE = 3'd3,
        S_READ  = 3'd4
    } state_e;

    typedef enum logic {
        G_WR = 1'b0,
        G_RD = 1'b1
    } grant_e;

endpackage

// File: rtl/sdram_cmd_mux.sv
// sdram_cmd_mux: selects the owning engine's command, address and bank for the SDRAM pins
module sdram_cmd_mux
    import sdram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BANK_W = DEF_BANK_W
) (
    input  state_e            state_i,
    input  logic [3:0]        init_cmd_i,
    input  logic [ADDR_W-1:0] init_addr_i,
    input  logic [3:0]        aref_cmd_i,
    input  logic [ADDR_W-1:0] aref_addr_i,
    input  logic [3:0]        wr_cmd_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [BANK_W-1:0] wr_bank_i,
    input  logic [3:0]        rd_cmd_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [BANK_W-1:0] rd_bank_i,
    output logic [3:0]        cmd_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [BANK_W-1:0] bank_o
);

    // arbitration and unused encodings drive NOP; init and refresh carry no bank
    always_comb begin
        cmd_o  = CMD_NOP;
        addr_o = '0;
        bank_o = '0;
        case (state_i)
            S_IDLE: begin
                cmd_o  = init_cmd_i;
                addr_o = init_addr_i;
            end
            S_AREF: begin
                cmd_o  = aref_cmd_i;
                addr_o = aref_addr_i;
            end
            S_WRITE: begin
                cmd_o  = wr_cmd_i;
                addr_o = wr_addr_i;
                bank_o = wr_bank_i;
            end
            S_READ: begin
                cmd_o  = rd_cmd_i;
                addr_o = rd_addr_i;
                bank_o = rd_bank_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: grants init/refresh/write/read engines the SDRAM bus with a completion watchdog
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int END_TIMEOUT = 1023,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int BANK_W      = DEF_BANK_W
) (
    input  logic              sclk,
    input  logic              s_rst,
    input  logic              init_done,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              aref_req,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BANK_W-1:0] rd_bank,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              aref_pending,
    output logic [3:0]        sdram_cmd,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [BANK_W-1:0] sdram_bank,
    output logic              timeout_err
);

    localparam int WD_W = $clog2(END_TIMEOUT + 1);

    state_e          state_q, state_d;
    grant_e          last_q, last_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
    logic            pend_q, pend_d;
    logic            aref_en_q, wr_en_q, rd_en_q;
    logic            active, act_end, wd_fire;

    assign active  = state_q == S_AREF | state_q == S_WRITE | state_q == S_READ;
    assign act_end = (state_q == S_AREF & aref_end) | (state_q == S_WRITE & wr_end) |
                     (state_q == S_READ & rd_end);
    assign wd_fire = active & wd_q == WD_W'(END_TIMEOUT - 1);

    // next state: refresh first, then write/read with alternation on a tie; engine end beats the watchdog
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE:  state_d = init_done ? S_ARBIT : S_IDLE;
            S_ARBIT: state_d = aref_req          ? S_AREF :
                               wr_req & rd_req   ? (last_q == G_RD ? S_WRITE : S_READ) :
                               wr_req            ? S_WRITE :
                               rd_req            ? S_READ : S_ARBIT;
            S_AREF, S_WRITE, S_READ: begin
                if (act_end) begin
                    state_d = S_ARBIT;
                end else if (wd_fire) begin
                    state_d = S_ARBIT;
                    err_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        last_d = state_q == S_ARBIT & state_d == S_WRITE ? G_WR :
                 state_q == S_ARBIT & state_d == S_READ  ? G_RD : last_d;
        wd_d   = active & state_d == state_q ? wd_q + 1'b1 : '0;
        pend_d = aref_req & (state_q == S_WRITE | state_q == S_READ) & state_d == state_q;
    end

    // state, watchdog and grant registers; grants track the state being entered
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state_q   <= S_IDLE;
            last_q    <= G_RD;
            wd_q      <= '0;
            err_q     <= 1'b0;
            pend_q    <= 1'b0;
            aref_en_q <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            wd_q      <= wd_d;
            err_q     <= err_d;
            pend_q    <= pend_d;
            aref_en_q <= state_d == S_AREF;
            wr_en_q   <= state_d == S_WRITE;
            rd_en_q   <= state_d == S_READ;
        end
    end

    assign aref_en      = aref_en_q;
    assign wr_en        = wr_en_q;
    assign rd_en        = rd_en_q;
    assign aref_pending = pend_q;
    assign timeout_err  = err_q;

    sdram_cmd_mux #(
        .ADDR_W(ADDR_W),
        .BANK_W(BANK_W)
    ) u_mux (
        .state_i    (state_q),
        .init_cmd_i (init_cmd),
        .init_addr_i(init_addr),
        .aref_cmd_i (aref_cmd),
        .aref_addr_i(aref_addr),
        .wr_cmd_i   (wr_cmd),
        .wr_addr_i  (wr_addr),
        .wr_bank_i  (wr_bank),
        .rd_cmd_i   (rd_cmd),
        .rd_addr_i  (rd_addr),
        .rd_bank_i  (rd_bank),
        .cmd_o      (sdram_cmd),
        .addr_o     (sdram_addr),
        .bank_o     (sdram_bank)
    );

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: random and directed stimulus against a cycle-level behavioural model of the arbiter
module tb_sdram_arbiter;

    localparam int TO = 15;
    localparam int AW = 13;
    localparam int BW = 2;
    localparam int M_IDLE = 0, M_ARB = 1, M_AREF = 2, M_WR = 3, M_RD = 4;

    logic          sclk = 1'b0, s_rst = 1'b0;
    logic          init_done = 1'b0, aref_req = 1'b0, aref_end = 1'b0;
    logic          wr_req = 1'b0, wr_end = 1'b0, rd_req = 1'b0, rd_end = 1'b0;
    logic [3:0]    init_cmd = '0, aref_cmd = '0, wr_cmd = '0, rd_cmd = '0;
    logic [AW-1:0] init_addr = '0, aref_addr = '0, wr_addr = '0, rd_addr = '0;
    logic [BW-1:0] wr_bank = '0, rd_bank = '0;
    logic          aref_en, wr_en, rd_en, aref_pending, timeout_err;
    logic [3:0]    sdram_cmd;
    logic [AW-1:0] sdram_addr;
    logic [BW-1:0] sdram_bank;

    sdram_arbiter #(.END_TIMEOUT(TO), .ADDR_W(AW), .BANK_W(BW)) dut (
        .sclk(sclk), .s_rst(s_rst), .init_done(init_done), .init_cmd(init_cmd), .init_addr(init_addr),
        .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .aref_pending(aref_pending),
        .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank), .timeout_err(timeout_err)
    );

    always #5 sclk = ~sclk;

    int n_cmp = 0, n_bad = 0;
    int m_mode = M_IDLE, m_age = 0;
    bit m_last_wr = 1'b0, m_err = 1'b0, m_pend = 1'b0;
    bit chk_on = 1'b0, rnd = 1'b0;
    int end_after = 0, g_prev = 0, run = 0, cnt;
    int gq[$];
    int lenq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_age = 0;
        m_last_wr = 1'b0;
        m_err = 1'b0;
        m_pend = 1'b0;
    endtask

    // one clock of the arbiter as described: who owns the bus next, for how long, and the sticky flags
    task automatic model_step();
        int nm;
        bit ended;
        if (s_rst) begin
            model_reset();
            return;
        end
        nm = m_mode;
        ended = (m_mode == M_AREF && aref_end) || (m_mode == M_WR && wr_end) || (m_mode == M_RD && rd_end);
        if (m_mode == M_IDLE) nm = init_done ? M_ARB : M_IDLE;
        else if (m_mode == M_ARB)
            nm = aref_req ? M_AREF : (wr_req && rd_req) ? (m_last_wr ? M_RD : M_WR) :
                 wr_req ? M_WR : rd_req ? M_RD : M_ARB;
        else if (ended) nm = M_ARB;
        else if (m_age == TO) begin
            nm = M_ARB;
            m_err = 1'b1;
        end
        m_pend = aref_req && (m_mode == M_WR || m_mode == M_RD) && nm == m_mode;
        if (nm == M_WR && m_mode != M_WR) m_last_wr = 1'b1;
        if (nm == M_RD && m_mode != M_RD) m_last_wr = 1'b0;
        m_age = (nm == m_mode) ? m_age + 1 : 1;
        m_mode = nm;
    endtask

    function automatic logic [3:0] exp_cmd();
        return m_mode == M_IDLE ? init_cmd : m_mode == M_AREF ? aref_cmd :
               m_mode == M_WR ? wr_cmd : m_mode == M_RD ? rd_cmd : 4'b0111;
    endfunction

    function automatic logic [AW-1:0] exp_addr();
        return m_mode == M_IDLE ? init_addr : m_mode == M_AREF ? aref_addr :
               m_mode == M_WR ? wr_addr : m_mode == M_RD ? rd_addr : '0;
    endfunction

    function automatic logic [BW-1:0] exp_bank();
        return m_mode == M_WR ? wr_bank : m_mode == M_RD ? rd_bank : '0;
    endfunction

    always @(negedge sclk) if (chk_on) begin
        chk("aref_en", 32'(aref_en), 32'(m_mode == M_AREF));
        chk("wr_en", 32'(wr_en), 32'(m_mode == M_WR));
        chk("rd_en", 32'(rd_en), 32'(m_mode == M_RD));
        chk("aref_pending", 32'(aref_pending), 32'(m_pend));
        chk("timeout_err", 32'(timeout_err), 32'(m_err));
        chk("sdram_cmd", 32'(sdram_cmd), 32'(exp_cmd()));
        chk("sdram_addr", 32'(sdram_addr), 32'(exp_addr()));
        chk("sdram_bank", 32'(sdram_bank), 32'(exp_bank()));
    end

    // advance one clock: model follows the edge, then fresh engine data and responder-driven ends
    task automatic step();
        int g;
        @(posedge sclk);
        model_step();
        #1;
        init_cmd = 4'($urandom); aref_cmd = 4'($urandom); wr_cmd = 4'($urandom); rd_cmd = 4'($urandom);
        init_addr = AW'($urandom); aref_addr = AW'($urandom); wr_addr = AW'($urandom); rd_addr = AW'($urandom);
        wr_bank = BW'($urandom); rd_bank = BW'($urandom);
        g = aref_en ? 1 : wr_en ? 2 : rd_en ? 3 : 0;
        if (g != g_prev && g_prev != 0) lenq.push_back(run);
        if (g != 0 && g != g_prev) gq.push_back(g);
        run = (g == 0) ? 0 : (g == g_prev) ? run + 1 : 1;
        g_prev = g;
        if (!rnd) begin
            aref_end = end_after > 0 && g == 1 && run == end_after;
            wr_end = end_after > 0 && g == 2 && run == end_after;
            rd_end = end_after > 0 && g == 3 && run == end_after;
        end
        #1;
    endtask

    task automatic rst_checks();
        chk("rst aref_en", 32'(aref_en), 0);
        chk("rst wr_en", 32'(wr_en), 0);
        chk("rst rd_en", 32'(rd_en), 0);
        chk("rst aref_pending", 32'(aref_pending), 0);
        chk("rst timeout_err", 32'(timeout_err), 0);
        chk("rst sdram_cmd", 32'(sdram_cmd), 32'(init_cmd));
        chk("rst sdram_bank", 32'(sdram_bank), 0);
    endtask

    // asynchronous reset asserted between edges, held across one edge
    task automatic do_reset();
        step();
        s_rst = 1'b1;
        model_reset();
        init_done = 1'b0; aref_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        aref_end = 1'b0; wr_end = 1'b0; rd_end = 1'b0;
        #1;
        rst_checks();
        step();
        s_rst = 1'b0;
    endtask

    task automatic enter_arbit();
        init_done = 1'b1;
        step();
        chk("arbit nop", 32'(sdram_cmd), 32'h7);
    endtask

    initial begin
        s_rst = 1'b1;
        model_reset();
        step();
        s_rst = 1'b0;
        chk_on = 1'b1;
        rst_checks();
        // init engine owns the pins until init_done
        for (int i = 0; i < 8; i++) step();
        chk("idle cmd", 32'(sdram_cmd), 32'(init_cmd));
        chk("idle addr", 32'(sdram_addr), 32'(init_addr));
        init_done = 1'b1;
        step();
        chk("arbit cmd", 32'(sdram_cmd), 32'h7);
        chk("arbit addr", 32'(sdram_addr), 0);
        init_done = 1'b0;

        // tie between write and read alternates, write first, 8-cycle bursts
        end_after = 8;
        gq.delete();
        lenq.delete();
        wr_req = 1'b1;
        rd_req = 1'b1;
        for (int i = 0; i < 80 && gq.size() < 5; i++) step();
        chk("tie grant count", 32'(gq.size() >= 4), 1);
        if (gq.size() >= 4) begin
            chk("tie grant 0", 32'(gq[0]), 2);
            chk("tie grant 1", 32'(gq[1]), 3);
            chk("tie grant 2", 32'(gq[2]), 2);
            chk("tie grant 3", 32'(gq[3]), 3);
        end
        if (lenq.size() >= 1) chk("wr burst len", 32'(lenq[0]), 8);
        wr_req = 1'b0;
        rd_req = 1'b0;
        for (int i = 0; i < 20; i++) step();

        // refresh requested mid-write is flagged, then wins over a pending read
        do_reset();
        enter_arbit();
        end_after = 0;
        wr_req = 1'b1;
        rd_req = 1'b1;
        for (int i = 0; i < 10 && !wr_en; i++) step();
        chk("wr granted", 32'(wr_en), 1);
        wr_req = 1'b0;
        step();
        step();
        aref_req = 1'b1;
        step();
        chk("aref_pending set", 32'(aref_pending), 1);
        for (int i = 0; i < 10 && run < 8; i++) step();
        wr_end = 1'b1;
        step();
        chk("post wr arbit aref_en", 32'(aref_en), 0);
        chk("post wr arbit pend", 32'(aref_pending), 0);
        chk("post wr arbit cmd", 32'(sdram_cmd), 32'h7);
        step();
        chk("aref beats rd", 32'(aref_en), 1);
        chk("rd held off", 32'(rd_en), 0);
        aref_req = 1'b0;
        rd_req = 1'b0;
        aref_end = 1'b1;
        step();
        end_after = 8;
        for (int i = 0; i < 20; i++) step();

        // write end and refresh request in the same cycle
        do_reset();
        enter_arbit();
        end_after = 0;
        wr_req = 1'b1;
        for (int i = 0; i < 10 && !wr_en; i++) step();
        chk("wr granted 2", 32'(wr_en), 1);
        wr_req = 1'b0;
        step();
        step();
        wr_end = 1'b1;
        aref_req = 1'b1;
        step();
        chk("same-cycle arbit", 32'(wr_en | aref_en), 0);
        chk("same-cycle nop", 32'(sdram_cmd), 32'h7);
        step();
        chk("same-cycle aref_en", 32'(aref_en), 1);
        chk("aref cmd", 32'(sdram_cmd), 32'(aref_cmd));
        chk("aref bank", 32'(sdram_bank), 0);
        aref_req = 1'b0;
        aref_end = 1'b1;
        step();

        // read engine that never ends trips the watchdog
        do_reset();
        enter_arbit();
        end_after = 0;
        rd_req = 1'b1;
        for (int i = 0; i < 10 && !rd_en; i++) step();
        rd_req = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40 && rd_en; i++) begin
            cnt++;
            step();
        end
        chk("watchdog rd cycles", 32'(cnt), TO);
        chk("timeout_err set", 32'(timeout_err), 1);
        for (int i = 0; i < 5; i++) step();
        chk("timeout_err sticky", 32'(timeout_err), 1);

        // reset arriving mid-read clears everything at once
        rd_req = 1'b1;
        for (int i = 0; i < 10 && !rd_en; i++) step();
        rd_req = 1'b0;
        step();
        chk("mid-read rd_en", 32'(rd_en), 1);
        do_reset();

        // randomized traffic, including ends for idle engines and watchdog expiries
        rnd = 1'b1;
        for (int r = 0; r < 20; r++) begin
            int ep;
            ep = (r % 3 == 0) ? 40 : (r % 3 == 1) ? 10 : 3;
            do_reset();
            for (int c = 0; c < 250; c++) begin
                step();
                if ($urandom_range(7) == 0) aref_req = ~aref_req;
                if ($urandom_range(5) == 0) wr_req = ~wr_req;
                if ($urandom_range(5) == 0) rd_req = ~rd_req;
                if ($urandom_range(6) == 0) init_done = ~init_done;
                aref_end = $urandom_range(ep - 1) == 0;
                wr_end = $urandom_range(ep - 1) == 0;
                rd_end = $urandom_range(ep - 1) == 0;
            end
        end
        rnd = 1'b0;
        step();
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
